// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN input-frame sequencer.
package snn_pkg;

    localparam int unsigned NUM_PIXELS_DEF  = 784;
    localparam int unsigned ADDR_WIDTH_DEF  = 10;
    localparam int unsigned TIMEOUT_CYC_DEF = 500000;
    localparam int unsigned TMR_W_DEF       = 19;

    localparam int unsigned BYTES_PER_FRAME = NUM_PIXELS_DEF / 8;
    localparam int unsigned PIX_LAST        = NUM_PIXELS_DEF - 1;

    localparam int unsigned BIT_W  = 3;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        UNPACK    = 3'd1,
        WAIT_BYTE = 3'd2,
        START     = 3'd3,
        INFER     = 3'd4,
        SEND      = 3'd5,
        WAIT_TX   = 3'd6
    } frame_state_t;

    // Result byte shown on the LEDs and sent back over the UART.
    typedef struct packed {
        logic [3:0] pad;
        logic [3:0] digit;
    } result_t;

    function automatic logic [BYTE_W-1:0] sat_inc8(input logic [BYTE_W-1:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/snn_frame_ctrl_timer.sv
// Inter-byte idle timer: counts while enabled, flags the last allowed cycle.
module frame_timer #(
    parameter int unsigned TIMEOUT_CYC = 500000,
    parameter int unsigned TMR_W       = 19
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TMR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == TMR_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/snn_frame_ctrl.sv
// Sequencer between UART, the 1-bit pixel RAM and snn_core: unpacks a frame,
// runs inference, reports the digit and drops bytes that arrive while busy.
module snn_frame_ctrl
    import snn_pkg::*;
#(
    parameter int unsigned NUM_PIXELS  = NUM_PIXELS_DEF,
    parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned TMR_W       = TMR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_rdy,
    input  logic [7:0]            rx_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_data,
    output logic                  ram_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    output logic                  core_start,
    input  logic                  core_done,
    input  logic [3:0]            core_digit,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    input  logic                  tx_rdy,
    output logic [7:0]            led,
    output logic                  busy,
    output logic                  frame_err,
    output logic [7:0]            drop_cnt
);

    localparam int unsigned PIX_LAST_L = NUM_PIXELS - 1;

    frame_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
    logic [BIT_W-1:0]      bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0]     byte_q, byte_d;
    logic [BYTE_W-1:0]     drop_q, drop_d;
    result_t               led_q, led_d;
    result_t               tx_data_q, tx_data_d;
    logic                  frame_err_q, frame_err_d;
    logic                  tx_first_q, tx_first_d;
    logic                  tmr_expired;
    logic                  in_wait;

    assign in_wait = (state_q == WAIT_BYTE);

    frame_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TMR_W       (TMR_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!in_wait),
        .en      (in_wait),
        .expired (tmr_expired)
    );

    // Next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        bit_idx_d   = bit_idx_q;
        byte_d      = byte_q;
        drop_d      = drop_q;
        led_d       = led_q;
        tx_data_d   = tx_data_q;
        frame_err_d = 1'b0;
        tx_first_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_rdy) begin
                    byte_d    = rx_data;
                    bit_idx_d = '0;
                    state_d   = UNPACK;
                end
            end
            UNPACK: begin
                pix_cnt_d = pix_cnt_q + ADDR_WIDTH'(1);
                bit_idx_d = bit_idx_q + BIT_W'(1);
                if (bit_idx_q == BIT_W'(7)) begin
                    state_d = (pix_cnt_q == ADDR_WIDTH'(PIX_LAST_L)) ? START : WAIT_BYTE;
                end
            end
            WAIT_BYTE: begin
                // A byte arriving on the expiring cycle still counts.
                if (rx_rdy) begin
                    byte_d    = rx_data;
                    bit_idx_d = '0;
                    state_d   = UNPACK;
                end else if (tmr_expired) begin
                    frame_err_d = 1'b1;
                    pix_cnt_d   = '0;
                    state_d     = IDLE;
                end
            end
            START: begin
                pix_cnt_d = '0;
                state_d   = INFER;
            end
            INFER: begin
                if (core_done) begin
                    led_d     = '{pad: 4'h0, digit: core_digit};
                    tx_data_d = '{pad: 4'h0, digit: core_digit};
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (tx_rdy) begin
                    tx_first_d = 1'b1;
                    state_d    = WAIT_TX;
                end
            end
            WAIT_TX: begin
                // uart_tx still reports idle on the cycle right after start.
                if (!tx_first_q && tx_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rx_rdy && (state_q inside {UNPACK, START, INFER, SEND, WAIT_TX})) begin
            drop_d = sat_inc8(drop_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pix_cnt_q   <= '0;
            bit_idx_q   <= '0;
            byte_q      <= '0;
            drop_q      <= '0;
            led_q       <= '0;
            tx_data_q   <= '0;
            frame_err_q <= 1'b0;
            tx_first_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            bit_idx_q   <= bit_idx_d;
            byte_q      <= byte_d;
            drop_q      <= drop_d;
            led_q       <= led_d;
            tx_data_q   <= tx_data_d;
            frame_err_q <= frame_err_d;
            tx_first_q  <= tx_first_d;
        end
    end

    // RAM port belongs to snn_core while it runs, otherwise to the unpacker.
    assign ram_addr   = (state_q == START || state_q == INFER) ? core_addr : pix_cnt_q;
    assign ram_data   = byte_q[bit_idx_q];
    assign ram_we     = (state_q == UNPACK);
    assign core_start = (state_q == START);
    assign tx_start   = (state_q == SEND) && tx_rdy;
    assign tx_data    = tx_data_q;
    assign led        = led_q;
    assign busy       = (state_q != IDLE);
    assign frame_err  = frame_err_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_snn_frame_ctrl.sv
// Scoreboard bench for snn_frame_ctrl with behavioural snn_core and uart_tx models.
`timescale 1ns/1ps
module tb_snn_frame_ctrl;

    localparam int unsigned TO_CYC   = 200;
    localparam int unsigned TMR_W    = 8;
    localparam int unsigned NPIX     = 784;
    localparam int unsigned AW       = 10;
    localparam int unsigned GAP      = 20;
    localparam int unsigned CORE_LAT = 1000;
    localparam int unsigned NBYTES   = snn_pkg::BYTES_PER_FRAME;

    logic          clk, rst_n;
    logic          rx_rdy;
    logic [7:0]    rx_data;
    logic [AW-1:0] ram_addr, core_addr;
    logic          ram_data, ram_we, core_start, core_done, tx_start, tx_rdy;
    logic [3:0]    core_digit;
    logic [7:0]    tx_data, led, drop_cnt;
    logic          busy, frame_err;
    logic          tx_idle, tx_bp;
    logic [3:0]    digit;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          data;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] tx_q[$];

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    int n_start = 0, n_tx = 0, n_err = 0, n_done = 0;
    int last_wr_cyc = 0, tx_cyc = 0, err_cyc = 0, rx_cyc = 0;
    int exp_pix = 0, exp_drop = 0;

    snn_frame_ctrl #(
        .NUM_PIXELS  (NPIX),
        .ADDR_WIDTH  (AW),
        .TIMEOUT_CYC (TO_CYC),
        .TMR_W       (TMR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_we     (ram_we),
        .core_addr  (core_addr),
        .core_start (core_start),
        .core_done  (core_done),
        .core_digit (core_digit),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_rdy     (tx_rdy),
        .led        (led),
        .busy       (busy),
        .frame_err  (frame_err),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign tx_rdy = tx_idle & ~tx_bp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: RAM writes, start, tx and error events.
    always @(negedge clk) begin
        wr_t e;
        if (ram_we) begin
            if (wr_q.size() == 0) begin
                chk("wr_unexpected", 32'(ram_addr), 32'hFFFF);
            end else begin
                e = wr_q.pop_front();
                chk("wr_addr", 32'(ram_addr), 32'(e.addr));
                chk("wr_data", 32'(ram_data), 32'(e.data));
            end
            if (ram_addr == AW'(NPIX - 1)) last_wr_cyc = cyc;
        end
        if (core_start) begin
            n_start++;
            chk("start_lat", 32'(cyc - last_wr_cyc), 32'd1);
        end
        if (tx_start) begin
            n_tx++;
            tx_cyc = cyc;
            if (tx_q.size() == 0) chk("tx_unexpected", 32'(tx_data), 32'h1FF);
            else chk("tx_data", 32'(tx_data), 32'(tx_q.pop_front()));
        end
        if (frame_err) begin
            n_err++;
            err_cyc = cyc;
        end
    end

    // snn_core model: done pulse with the current digit CORE_LAT cycles after start.
    initial begin
        core_done  = 1'b0;
        core_digit = 4'h0;
        forever begin
            @(negedge clk);
            if (core_start) begin
                repeat (CORE_LAT) @(posedge clk);
                #1;
                core_digit = digit;
                core_done  = 1'b1;
                tx_q.push_back({4'h0, digit});
                n_done++;
                @(posedge clk);
                #1 core_done = 1'b0;
            end
        end
    end

    // uart_tx model: rdy stays high one more cycle after start, then low for 50.
    initial begin
        tx_idle = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                @(posedge clk);
                @(posedge clk);
                #1 tx_idle = 1'b0;
                @(negedge clk);
                chk("busy_wait_tx", 32'(busy), 32'd1);
                repeat (50) @(posedge clk);
                #1 tx_idle = 1'b1;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        wr_t w;
        @(posedge clk);
        #1;
        rx_data = b;
        rx_rdy  = 1'b1;
        rx_cyc  = cyc;
        for (int k = 0; k < 8; k++) begin
            w.addr = AW'(exp_pix + k);
            w.data = b[k];
            wr_q.push_back(w);
        end
        exp_pix += 8;
        if (exp_pix == int'(NPIX)) exp_pix = 0;
        @(posedge clk);
        #1 rx_rdy = 1'b0;
        repeat (gap - 2) @(posedge clk);
    endtask

    task automatic drop_byte(input int gap);
        @(posedge clk);
        #1;
        rx_data  = 8'($urandom);
        rx_rdy   = 1'b1;
        exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
        @(posedge clk);
        #1 rx_rdy = 1'b0;
        repeat (gap - 2) @(posedge clk);
    endtask

    task automatic send_frame(input int mode, input int race_at, input int drop_at, input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            logic [7:0] b;
            int         gap;
            b   = (mode == 0) ? 8'hA5 : 8'($urandom);
            gap = (i + 1 == race_at) ? int'(TO_CYC + 8) : int'(GAP);
            if (i == drop_at) begin
                send_byte(b, 3);
                drop_byte(GAP - 3);
            end else begin
                send_byte(b, gap);
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 5000);
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_led"}, 32'(led), 32'd0);
        chk({tag, "_txd"}, 32'(tx_data), 32'd0);
        chk({tag, "_drop"}, 32'(drop_cnt), 32'd0);
        chk({tag, "_we"}, 32'(ram_we), 32'd0);
        chk({tag, "_start"}, 32'(core_start), 32'd0);
        chk({tag, "_txs"}, 32'(tx_start), 32'd0);
        chk({tag, "_err"}, 32'(frame_err), 32'd0);
        chk({tag, "_addr"}, 32'(ram_addr), 32'd0);
    endtask

    // Frame-level check after a completed inference.
    task automatic chk_result(input string tag, input int s0, input int t0, input logic [3:0] d);
        chk({tag, "_led"}, 32'(led), 32'({4'h0, d}));
        chk({tag, "_nstart"}, 32'(n_start - s0), 32'd1);
        chk({tag, "_ntx"}, 32'(n_tx - t0), 32'd1);
        chk({tag, "_wrq"}, 32'(wr_q.size()), 32'd0);
    endtask

    initial begin
        int s0, t0, e0, d0, n, rel_cyc;
        rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00;
        core_addr = '0; tx_bp = 1'b0; digit = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Full frame of 0xA5, digit 7, plus address mux during INFER.
        digit = 4'h7; s0 = n_start; t0 = n_tx;
        send_frame(0, -1, -1, NBYTES);
        repeat (100) @(posedge clk);
        #1 core_addr = AW'(10'h155);
        @(negedge clk);
        chk("mux_infer_addr", 32'(ram_addr), 32'h155);
        chk("mux_infer_we", 32'(ram_we), 32'd0);
        wait_idle("idle_f1");
        chk_result("f1", s0, t0, 4'h7);

        // Timeout after 10 bytes; mux must show pix_cnt in WAIT_BYTE.
        e0 = n_err; s0 = n_start;
        send_frame(1, -1, -1, 10);
        @(negedge clk);
        chk("mux_wait_addr", 32'(ram_addr), 32'd80);
        repeat (TO_CYC + 50) @(posedge clk);
        chk("to_err_once", 32'(n_err - e0), 32'd1);
        chk("to_err_cyc", 32'(err_cyc - rx_cyc), 32'(TO_CYC + 9));
        chk("to_no_start", 32'(n_start - s0), 32'd0);
        chk("to_idle", 32'(busy), 32'd0);
        exp_pix = 0;
        digit = 4'h3; s0 = n_start; t0 = n_tx;
        send_frame(1, -1, -1, NBYTES);
        wait_idle("idle_f2");
        chk_result("f2", s0, t0, 4'h3);

        // Byte lands exactly on the expiring cycle.
        digit = 4'h9; s0 = n_start; t0 = n_tx; e0 = n_err;
        send_frame(1, 5, -1, NBYTES);
        wait_idle("idle_race");
        chk("race_no_err", 32'(n_err - e0), 32'd0);
        chk_result("race", s0, t0, 4'h9);

        // One drop during UNPACK, three during INFER.
        digit = 4'h4; s0 = n_start; t0 = n_tx;
        send_frame(1, -1, 40, NBYTES);
        repeat (30) @(posedge clk);
        for (int i = 0; i < 3; i++) drop_byte(GAP);
        wait_idle("idle_drop");
        chk("drop_cnt_4", 32'(drop_cnt), 32'(exp_drop));
        chk_result("drop", s0, t0, 4'h4);

        // 300 drops saturate the counter.
        digit = 4'h2; s0 = n_start; t0 = n_tx;
        send_frame(1, -1, -1, NBYTES);
        repeat (5) @(posedge clk);
        for (int i = 0; i < 300; i++) drop_byte(2);
        wait_idle("idle_sat");
        chk("drop_cnt_sat", 32'(drop_cnt), 32'(exp_drop));
        chk_result("sat", s0, t0, 4'h2);

        // Reset in the middle of a frame.
        send_frame(1, -1, -1, 50);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk_reset("rst_mid");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_reset("rst_rel");
        chk("rst_wrq", 32'(wr_q.size()), 32'd0);
        exp_pix = 0; exp_drop = 0;
        digit = 4'h5; s0 = n_start; t0 = n_tx;
        send_frame(1, -1, -1, NBYTES);
        wait_idle("idle_rst");
        chk_result("rst", s0, t0, 4'h5);
        chk("rst_drop", 32'(drop_cnt), 32'(exp_drop));

        // TX backpressure for 200 cycles after core_done.
        digit = 4'h8; s0 = n_start; t0 = n_tx; d0 = n_done;
        tx_bp = 1'b1;
        send_frame(1, -1, -1, NBYTES);
        n = 0;
        while (n_done == d0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("bp_done_seen", 32'(n_done - d0), 32'd1);
        repeat (200) @(posedge clk);
        chk("bp_no_tx", 32'(n_tx - t0), 32'd0);
        #1;
        tx_bp   = 1'b0;
        rel_cyc = cyc;
        wait_idle("idle_bp");
        chk("bp_tx_cyc", 32'(tx_cyc), 32'(rel_cyc));
        chk_result("bp", s0, t0, 4'h8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
